frame_fifo_write: RTL and testbench
===================================

FRAME_FIFO_WRITE -- requirements
Module: frame_fifo_write

Interface
REQ-001 SHALL have parameter MEM_DATA_BITS, default 16, SDRAM word width.
REQ-002 SHALL have parameter ADDR_BITS, default 24, SDRAM word-address width.
REQ-003 SHALL have parameter BURST_BITS, default 10, burst-length field width.
REQ-004 SHALL have parameter BURST_SIZE, default 128, maximum words per burst (1..2^BURST_BITS-1).
REQ-005 SHALL have port clk  in  1  memory clock, single clock domain. Reset is synchronous and active-high.
REQ-006 SHALL have port rst  in  1  synchronous active-high reset.
REQ-007 SHALL have port write_req  in  1  frame-write request (level).
REQ-008 SHALL have port write_req_ack  out  1  request acknowledge.
REQ-009 SHALL have port write_finish  out  1  one-cycle end-of-frame pulse.
REQ-010 SHALL have ports write_addr_0..write_addr_3  in  ADDR_BITS each  frame-buffer base addresses.
REQ-011 SHALL have port write_addr_index  in  2  base-address select.
REQ-012 SHALL have port write_len  in  ADDR_BITS  words per frame.
REQ-013 SHALL have port fifo_rd_data_count  in  16  pixel-FIFO fill level, in words.
REQ-014 SHALL have port fifo_rd_en  out  1  pixel-FIFO pop.
REQ-015 SHALL have ports wr_burst_req (out 1), wr_burst_len (out BURST_BITS), wr_burst_addr (out ADDR_BITS), wr_burst_data_req (in 1), wr_burst_finish (in 1).
- These ports form the sdram_core write port.

Function
REQ-016 SHALL implement the states IDLE, ACK, CHECK_FIFO, WRITE_BURST and WRITE_END.
REQ-017 IDLE: when write_req=1, SHALL latch base=write_addr_[write_addr_index], cur_addr=base and remaining=write_len, then go to ACK.
REQ-018 ACK: SHALL drive write_req_ack=1 and hold it until write_req=0, then go to CHECK_FIFO (4-phase handshake).
REQ-019 CHECK_FIFO: len=min(BURST_SIZE, remaining).
- remaining==0 -> WRITE_END.
- fifo_rd_data_count>=len -> register wr_burst_req=1, wr_burst_len=len, wr_burst_addr=cur_addr, go to WRITE_BURST.
- Otherwise stay.
REQ-020 WRITE_BURST: SHALL hold wr_burst_req, wr_burst_len and wr_burst_addr stable until wr_burst_finish.
REQ-021 SHALL drive fifo_rd_en = wr_burst_data_req combinationally while in WRITE_BURST, and 0 in every other state.
REQ-022 On wr_burst_finish, SHALL perform all of the following in the same edge:
- wr_burst_req<=0;
- cur_addr<=cur_addr+len, modulo 2^ADDR_BITS;
- remaining<=remaining-len;
- go to CHECK_FIFO.
- This gives a minimum one-cycle gap between bursts.
REQ-023 WRITE_END: SHALL pulse write_finish for exactly one cycle, then go to IDLE.
REQ-024 write_len=0 SHALL produce ack, no burst, then a write_finish pulse.
REQ-025 The final burst SHALL be short when remaining<BURST_SIZE; remaining SHALL never underflow.
REQ-026 write_req asserted outside IDLE SHALL be ignored.
REQ-027 The address inputs SHALL be sampled only in IDLE; changes mid-frame SHALL have no effect.
REQ-028 wr_burst_finish arriving outside WRITE_BURST SHALL be ignored.
REQ-029 Address and length arithmetic SHALL be unsigned; len SHALL be zero-extended to ADDR_BITS before addition.

Reset
REQ-030 With rst=1 at a clk edge, SHALL enter IDLE and clear all of the following to 0:
- wr_burst_req, wr_burst_len, wr_burst_addr;
- write_req_ack, write_finish, fifo_rd_en;
- cur_addr, remaining.
REQ-031 Reset mid-burst SHALL drop wr_burst_req the following cycle, with no finish pulse; the in-flight burst is abandoned.

Structure
REQ-032 The state encodings and the default BURST_SIZE SHALL live in the shared sdram/io definitions package alongside frame_fifo_read's constants.
REQ-033 SHALL be a single module with no sub-modules; the min() burst-length calculation SHALL be inline.

Verification
REQ-034 Frame: write_len=300, BURST_SIZE=128, base=0x000100, FIFO full -> bursts (addr 0x000100, len 128), (0x000180, 128), (0x000200, 44), then one write_finish pulse.
REQ-035 Starvation: fifo_rd_data_count=100, write_len=128 -> no wr_burst_req until the count reaches 128, then a burst at the first eligible edge.
REQ-036 Index select: write_addr_2=0x012C00, index=2, write_len=16 -> one burst, addr 0x012C00, len 16; write_req_ack stays high until write_req falls.
REQ-037 Zero length: write_len=0 -> ack, no wr_burst_req, write_finish pulse of exactly 1 cycle.
REQ-038 Wrap: base=0xFFFFC0, write_len=128, BURST_SIZE=64 -> bursts at 0xFFFFC0, then 0x000000.
REQ-039 Reset mid-burst: rst after 10 of 128 data_req cycles -> all outputs 0 next cycle, IDLE; a new write_req restarts from the newly latched base.

Source files
------------

// File: rtl/frame_fifo_write_pkg.sv
// Shared sdram/io definitions for the frame FIFO movers: frame-writer
// FSM encodings and default burst sizing.
package frame_fifo_write_pkg;

    localparam int DEFAULT_BURST_SIZE = 128;
    localparam int DEFAULT_BURST_BITS = 10;
    localparam int FIFO_COUNT_BITS    = 16;

    typedef enum logic [2:0] {
        WR_IDLE        = 3'd0,
        WR_ACK         = 3'd1,
        WR_CHECK_FIFO  = 3'd2,
        WR_WRITE_BURST = 3'd3,
        WR_WRITE_END   = 3'd4
    } wr_state_t;

endpackage

// File: rtl/frame_fifo_write_if.sv
// sdram_core write-burst port: request/length/address out, data strobe and
// burst completion back.
interface frame_fifo_write_if
    import frame_fifo_write_pkg::*;
#(
    parameter int ADDR_BITS  = 24,
    parameter int BURST_BITS = DEFAULT_BURST_BITS
) ();

    logic                  wr_burst_req;
    logic [BURST_BITS-1:0] wr_burst_len;
    logic [ADDR_BITS-1:0]  wr_burst_addr;
    logic                  wr_burst_data_req;
    logic                  wr_burst_finish;

    modport master (
        output wr_burst_req,
        output wr_burst_len,
        output wr_burst_addr,
        input  wr_burst_data_req,
        input  wr_burst_finish
    );

    modport slave (
        input  wr_burst_req,
        input  wr_burst_len,
        input  wr_burst_addr,
        output wr_burst_data_req,
        output wr_burst_finish
    );

endinterface

// File: rtl/frame_fifo_write.sv
// Frame writer: moves one frame from the pixel FIFO into SDRAM as a series
// of bursts of at most BURST_SIZE words, starting at a selectable base.
//
//   state          | meaning
//   ---------------+-----------------------------------------------------
//   WR_IDLE        | wait for write_req, latch base address and length
//   WR_ACK         | hold write_req_ack until write_req drops
//   WR_CHECK_FIFO  | end frame if nothing left, else wait for enough data
//   WR_WRITE_BURST | burst in flight; FIFO pops follow wr_burst_data_req
//   WR_WRITE_END   | one-cycle write_finish pulse
module frame_fifo_write
    import frame_fifo_write_pkg::*;
#(
    parameter int MEM_DATA_BITS = 16,
    parameter int ADDR_BITS     = 24,
    parameter int BURST_BITS    = DEFAULT_BURST_BITS,
    parameter int BURST_SIZE    = DEFAULT_BURST_SIZE
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       write_req,
    output logic                       write_req_ack,
    output logic                       write_finish,
    input  logic [ADDR_BITS-1:0]       write_addr_0,
    input  logic [ADDR_BITS-1:0]       write_addr_1,
    input  logic [ADDR_BITS-1:0]       write_addr_2,
    input  logic [ADDR_BITS-1:0]       write_addr_3,
    input  logic [1:0]                 write_addr_index,
    input  logic [ADDR_BITS-1:0]       write_len,
    input  logic [FIFO_COUNT_BITS-1:0] fifo_rd_data_count,
    output logic                       fifo_rd_en,
    frame_fifo_write_if.master         wr
);

    if (MEM_DATA_BITS < 1 || BURST_SIZE < 1 || BURST_SIZE > (2 ** BURST_BITS) - 1) begin : g_param_check
        $error("frame_fifo_write: BURST_SIZE must fit in BURST_BITS and widths must be positive");
    end

    localparam logic [ADDR_BITS-1:0] BURST_WORDS_MAX = ADDR_BITS'(BURST_SIZE);

    wr_state_t            state;
    wr_state_t            state_next;
    logic [ADDR_BITS-1:0] cur_addr;
    logic [ADDR_BITS-1:0] remaining;
    logic [ADDR_BITS-1:0] burst_words;
    logic [ADDR_BITS-1:0] addr_sel;
    logic [ADDR_BITS-1:0] burst_len_ext;
    logic                 fifo_ready;

    // Next burst size (short tail burst) and whether the FIFO holds enough for it.
    always_comb begin
        burst_words   = (remaining < BURST_WORDS_MAX) ? remaining : BURST_WORDS_MAX;
        fifo_ready    = {{ADDR_BITS{1'b0}}, fifo_rd_data_count} >= {{FIFO_COUNT_BITS{1'b0}}, burst_words};
        burst_len_ext = {{(ADDR_BITS-BURST_BITS){1'b0}}, wr.wr_burst_len};
    end

    // Base-address select, only consumed in WR_IDLE.
    always_comb begin
        case (write_addr_index)
            2'd0:    addr_sel = write_addr_0;
            2'd1:    addr_sel = write_addr_1;
            2'd2:    addr_sel = write_addr_2;
            default: addr_sel = write_addr_3;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= WR_IDLE;
        else     state <= state_next;
    end

    // Next-state decode.
    always_comb begin
        state_next = state;
        case (state)
            WR_IDLE:        if (write_req) state_next = WR_ACK;
            WR_ACK:         if (!write_req) state_next = WR_CHECK_FIFO;
            WR_CHECK_FIFO: begin
                if (remaining == '0)  state_next = WR_WRITE_END;
                else if (fifo_ready)  state_next = WR_WRITE_BURST;
            end
            WR_WRITE_BURST: if (wr.wr_burst_finish) state_next = WR_CHECK_FIFO;
            WR_WRITE_END:   state_next = WR_IDLE;
            default:        state_next = WR_IDLE;
        endcase
    end

    // Handshake outputs decoded from the current state.
    always_comb begin
        write_req_ack = (state == WR_ACK);
        write_finish  = (state == WR_WRITE_END);
        fifo_rd_en    = (state == WR_WRITE_BURST) && wr.wr_burst_data_req;
    end

    // Frame progress and registered burst command.
    always_ff @(posedge clk) begin
        if (rst) begin
            cur_addr         <= '0;
            remaining        <= '0;
            wr.wr_burst_req  <= 1'b0;
            wr.wr_burst_len  <= '0;
            wr.wr_burst_addr <= '0;
        end else begin
            case (state)
                WR_IDLE: begin
                    if (write_req) begin
                        cur_addr  <= addr_sel;
                        remaining <= write_len;
                    end
                end
                WR_CHECK_FIFO: begin
                    if (remaining != '0 && fifo_ready) begin
                        wr.wr_burst_req  <= 1'b1;
                        wr.wr_burst_len  <= burst_words[BURST_BITS-1:0];
                        wr.wr_burst_addr <= cur_addr;
                    end
                end
                WR_WRITE_BURST: begin
                    if (wr.wr_burst_finish) begin
                        wr.wr_burst_req <= 1'b0;
                        cur_addr        <= cur_addr + burst_len_ext;
                        remaining       <= remaining - burst_len_ext;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_frame_fifo_write.sv
// Bench for frame_fifo_write: two DUTs (BURST_SIZE 128 and 64) share the
// request side; each has its own sdram write-port responder that logs bursts.
module tb_frame_fifo_write;
    localparam int AW = 24;
    localparam int BW = 10;
    localparam logic [AW-1:0] BASE0 = 24'h000100;
    localparam logic [AW-1:0] BASE1 = 24'hFFFFC0;
    localparam logic [AW-1:0] BASE2 = 24'h012C00;
    localparam logic [AW-1:0] BASE3 = 24'h00F000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          write_req;
    logic [AW-1:0] write_addr_0, write_addr_1, write_addr_2, write_addr_3;
    logic [1:0]    write_addr_index;
    logic [AW-1:0] write_len;
    logic [15:0]   fifo_cnt;
    logic          ack0, ack1, wfin0, wfin1, rden0, rden1;

    frame_fifo_write_if #(.ADDR_BITS(AW), .BURST_BITS(BW)) wr0 ();
    frame_fifo_write_if #(.ADDR_BITS(AW), .BURST_BITS(BW)) wr1 ();

    frame_fifo_write #(.ADDR_BITS(AW), .BURST_BITS(BW), .BURST_SIZE(128)) u_dut0 (
        .clk(clk), .rst(rst), .write_req(write_req), .write_req_ack(ack0),
        .write_finish(wfin0), .write_addr_0(write_addr_0), .write_addr_1(write_addr_1),
        .write_addr_2(write_addr_2), .write_addr_3(write_addr_3),
        .write_addr_index(write_addr_index), .write_len(write_len),
        .fifo_rd_data_count(fifo_cnt), .fifo_rd_en(rden0), .wr(wr0));

    frame_fifo_write #(.ADDR_BITS(AW), .BURST_BITS(BW), .BURST_SIZE(64)) u_dut1 (
        .clk(clk), .rst(rst), .write_req(write_req), .write_req_ack(ack1),
        .write_finish(wfin1), .write_addr_0(write_addr_0), .write_addr_1(write_addr_1),
        .write_addr_2(write_addr_2), .write_addr_3(write_addr_3),
        .write_addr_index(write_addr_index), .write_len(write_len),
        .fifo_rd_data_count(fifo_cnt), .fifo_rd_en(rden1), .wr(wr1));

    // responder state, one slot per DUT
    logic          dr   [2] = '{1'b0, 1'b0};
    logic          rf   [2] = '{1'b0, 1'b0};
    logic          xfin [2] = '{1'b0, 1'b0};
    bit            busy [2];
    int            bcnt [2], nb [2], pops [2], fins [2], perr [2], drq [2];
    int            s_nb [2], s_pops [2], s_fins [2], s_perr [2], s_drq [2];
    logic [AW-1:0] log_addr [2][256];
    logic [BW-1:0] log_len  [2][256];
    logic          req_v [2], rden_v [2], fin_v [2];
    logic [AW-1:0] addr_v [2];
    logic [BW-1:0] len_v [2];

    assign wr0.wr_burst_data_req = dr[0];
    assign wr0.wr_burst_finish   = rf[0] | xfin[0];
    assign wr1.wr_burst_data_req = dr[1];
    assign wr1.wr_burst_finish   = rf[1] | xfin[1];
    assign req_v[0]  = wr0.wr_burst_req;   assign req_v[1]  = wr1.wr_burst_req;
    assign addr_v[0] = wr0.wr_burst_addr;  assign addr_v[1] = wr1.wr_burst_addr;
    assign len_v[0]  = wr0.wr_burst_len;   assign len_v[1]  = wr1.wr_burst_len;
    assign rden_v[0] = rden0;              assign rden_v[1] = rden1;
    assign fin_v[0]  = wfin0;              assign fin_v[1]  = wfin1;

    // sdram write-port model: accept a burst, strobe data_req len cycles, pulse finish
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (rden_v[d] !== (dr[d] & req_v[d])) perr[d]++;
            pops[d] += int'(rden_v[d]);
            fins[d] += int'(fin_v[d]);
            if (rst) begin
                dr[d] = 1'b0; rf[d] = 1'b0; busy[d] = 1'b0; bcnt[d] = 0;
            end else begin
                rf[d] = 1'b0;
                if (!busy[d] && req_v[d]) begin
                    busy[d] = 1'b1; bcnt[d] = 0;
                    log_addr[d][nb[d] % 256] = addr_v[d];
                    log_len[d][nb[d] % 256]  = len_v[d];
                    nb[d]++;
                end
                if (busy[d]) begin
                    if (bcnt[d] < int'(len_v[d])) begin
                        dr[d] = 1'b1; bcnt[d]++; drq[d]++;
                    end else begin
                        dr[d] = 1'b0; rf[d] = 1'b1; busy[d] = 1'b0;
                    end
                end
            end
        end
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    task automatic restore_inputs();
        write_addr_0 = BASE0; write_addr_1 = BASE1;
        write_addr_2 = BASE2; write_addr_3 = BASE3;
    endtask

    task automatic frame_start(input logic [1:0] idx, input int len);
        bit held;
        restore_inputs();
        write_addr_index = idx;
        write_len = AW'(len);
        for (int d = 0; d < 2; d++) begin
            s_nb[d] = nb[d]; s_pops[d] = pops[d]; s_fins[d] = fins[d];
            s_perr[d] = perr[d]; s_drq[d] = drq[d];
        end
        write_req = 1'b1;
        for (int i = 0; i < 20 && !(ack0 && ack1); i++) @(negedge clk);
        chk("ack_rise", {30'd0, ack1, ack0}, 32'd3);
        held = 1'b1;
        repeat (3) begin
            @(negedge clk);
            held &= (ack0 & ack1);
        end
        chk("ack_hold", {31'd0, held}, 32'd1);
        write_req = 1'b0;
        // address/length inputs are don't-care once the frame is latched
        write_addr_0 = 24'h5A5A5A; write_addr_1 = 24'h123456;
        write_addr_2 = 24'hA5A5A5; write_addr_3 = 24'h654321;
        write_len = 24'd7;
        @(negedge clk);
        chk("ack_fall", {30'd0, ack1, ack0}, 32'd0);
    endtask

    task automatic frame_end();
        int i;
        for (i = 0; i < 4000 && !(fins[0] > s_fins[0] && fins[1] > s_fins[1]); i++) @(negedge clk);
        chk("frame_done", {31'd0, (fins[0] > s_fins[0] && fins[1] > s_fins[1])}, 32'd1);
        repeat (4) @(negedge clk);
    endtask

    task automatic check_dut(input int d, input int n, input int fa, input int fl,
                             input int la, input int ll, input int words);
        int got_n;
        int gaps;
        int k;
        got_n = nb[d] - s_nb[d];
        gaps = 0;
        chk($sformatf("d%0d_bursts", d), got_n, n);
        if (got_n > 0 && n > 0) begin
            k = s_nb[d] % 256;
            chk($sformatf("d%0d_first_addr", d), 32'(log_addr[d][k]), fa);
            chk($sformatf("d%0d_first_len", d), 32'(log_len[d][k]), fl);
            k = (nb[d] - 1) % 256;
            chk($sformatf("d%0d_last_addr", d), 32'(log_addr[d][k]), la);
            chk($sformatf("d%0d_last_len", d), 32'(log_len[d][k]), ll);
        end
        for (int i = 1; i < got_n; i++) begin
            k = (s_nb[d] + i) % 256;
            if (log_addr[d][k] != log_addr[d][(k + 255) % 256] + AW'(log_len[d][(k + 255) % 256]))
                gaps++;
        end
        chk($sformatf("d%0d_contig", d), gaps, 0);
        chk($sformatf("d%0d_pops", d), pops[d] - s_pops[d], words);
        chk($sformatf("d%0d_finish_cycles", d), fins[d] - s_fins[d], 1);
        chk($sformatf("d%0d_rden_gating", d), perr[d] - s_perr[d], 0);
    endtask

    typedef struct {
        logic [1:0] idx;
        int len;
        int n0, fa0, fl0, la0, ll0;
        int n1, fa1, fl1, la1, ll1;
    } vec_t;

    vec_t tv [5];

    initial begin
        bit ack_seen;
        // idx, len | DUT0 (128): n, first addr/len, last addr/len | DUT1 (64): same
        tv[0] = '{2'd0, 300, 3, 'h000100, 128, 'h000200, 44, 5, 'h000100, 64, 'h000200, 44};
        tv[1] = '{2'd2, 16,  1, 'h012C00, 16,  'h012C00, 16, 1, 'h012C00, 16, 'h012C00, 16};
        tv[2] = '{2'd0, 0,   0, 0, 0, 0, 0,                   0, 0, 0, 0, 0};
        tv[3] = '{2'd1, 128, 1, 'hFFFFC0, 128, 'hFFFFC0, 128, 2, 'hFFFFC0, 64, 'h000000, 64};
        tv[4] = '{2'd3, 129, 2, 'h00F000, 128, 'h00F080, 1,   3, 'h00F000, 64, 'h00F080, 1};

        rst = 1'b1; write_req = 1'b0; write_addr_index = 2'd0; write_len = '0;
        fifo_cnt = 16'd1000;
        restore_inputs();
        repeat (3) @(negedge clk);
        chk("rst_req",    {31'd0, wr0.wr_burst_req}, 32'd0);
        chk("rst_len",    32'(wr0.wr_burst_len), 32'd0);
        chk("rst_addr",   32'(wr0.wr_burst_addr), 32'd0);
        chk("rst_ack",    {31'd0, ack0}, 32'd0);
        chk("rst_finish", {31'd0, wfin0}, 32'd0);
        chk("rst_rden",   {31'd0, rden0}, 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        for (int v = 0; v < 5; v++) begin
            frame_start(tv[v].idx, tv[v].len);
            frame_end();
            check_dut(0, tv[v].n0, tv[v].fa0, tv[v].fl0, tv[v].la0, tv[v].ll0, tv[v].len);
            check_dut(1, tv[v].n1, tv[v].fa1, tv[v].fl1, tv[v].la1, tv[v].ll1, tv[v].len);
        end

        // FIFO starvation, with a stray request and stray finish while waiting
        fifo_cnt = 16'd100;
        frame_start(2'd0, 128);
        repeat (20) @(negedge clk);
        chk("starve_no_req", {31'd0, wr0.wr_burst_req}, 32'd0);
        chk("starve_no_burst", nb[0] - s_nb[0], 0);
        write_req = 1'b1;
        xfin[0] = 1'b1;
        @(negedge clk);
        xfin[0] = 1'b0;
        ack_seen = ack0;
        repeat (3) begin
            @(negedge clk);
            ack_seen |= ack0;
        end
        write_req = 1'b0;
        chk("busy_req_ignored", {31'd0, ack_seen}, 32'd0);
        fifo_cnt = 16'd128;
        @(negedge clk);
        chk("starve_req_edge", {31'd0, wr0.wr_burst_req}, 32'd1);
        chk("starve_addr", 32'(wr0.wr_burst_addr), 32'h000100);
        chk("starve_len", 32'(wr0.wr_burst_len), 32'd128);
        frame_end();
        check_dut(0, 1, 'h000100, 128, 'h000100, 128, 128);
        check_dut(1, 2, 'h000100, 64, 'h000140, 64, 128);

        // reset in the middle of a burst, then a fresh frame from another base
        fifo_cnt = 16'd1000;
        frame_start(2'd0, 300);
        for (int i = 0; i < 400 && (drq[0] - s_drq[0]) < 10; i++) @(negedge clk);
        chk("rst_inflight", {31'd0, wr0.wr_burst_req}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("mrst_req",    {31'd0, wr0.wr_burst_req}, 32'd0);
        chk("mrst_len",    32'(wr0.wr_burst_len), 32'd0);
        chk("mrst_addr",   32'(wr0.wr_burst_addr), 32'd0);
        chk("mrst_ack",    {31'd0, ack0}, 32'd0);
        chk("mrst_finish", {31'd0, wfin0}, 32'd0);
        chk("mrst_rden",   {31'd0, rden0}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        chk("mrst_no_finish", fins[0] - s_fins[0], 0);
        repeat (2) @(negedge clk);
        frame_start(2'd2, 16);
        frame_end();
        check_dut(0, 1, 'h012C00, 16, 'h012C00, 16, 16);
        check_dut(1, 1, 'h012C00, 16, 'h012C00, 16, 16);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
